// File: rtl/wf_pkg.sv
// Shared types and default sizing for the waveform DPBRAM playback engine.
package wf_pkg;

  localparam int unsigned WF_ADDR_WIDTH  = 10;
  localparam int unsigned WF_DATA_WIDTH  = 16;
  localparam int unsigned WF_RAM_LATENCY = 2;
  localparam int unsigned WF_DEPTH       = 1 << WF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DONE
  } wf_state_t;

endpackage

// File: rtl/wf_dpbram_player.sv
// Waveform playback: prefetches one DPBRAM sample ahead and releases it to
// the Core IP setpoint on each sample tick, in one-shot or loop mode.
module wf_dpbram_player
  import wf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = WF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = WF_DATA_WIDTH,
  parameter int unsigned RAM_LATENCY = WF_RAM_LATENCY
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wf_start,
  input  logic                  i_wf_loop,
  input  logic [31:0]           i_wf_max_cnt,
  input  logic                  i_wf_tick,
  output logic [ADDR_WIDTH-1:0] o_wf_ram_addr,
  output logic                  o_wf_ram_ce,
  output logic                  o_wf_ram_we,
  output logic [DATA_WIDTH-1:0] o_wf_ram_din,
  input  logic [DATA_WIDTH-1:0] i_wf_ram_dout,
  output logic [DATA_WIDTH-1:0] o_wf_data,
  output logic                  o_wf_data_valid,
  output logic [31:0]           o_wf_read_cnt,
  output logic                  o_wf_busy,
  output logic                  o_wf_done,
  output logic                  o_wf_underrun
);

  localparam int unsigned MW    = ADDR_WIDTH + 1;
  localparam int unsigned LW    = 3;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  wf_state_t             state_q, state_d;
  logic                  start_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MW-1:0]         max_q, max_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [DATA_WIDTH-1:0] pref_q, pref_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  under_q, under_d;
  logic                  ce_q, busy_q, done_q;

  logic          start_edge;
  logic [MW-1:0] max_clamp;
  logic          last_sample;

  assign start_edge  = i_wf_start & ~start_q;
  assign max_clamp   = (i_wf_max_cnt > DEPTH) ? MW'(DEPTH) : MW'(i_wf_max_cnt);
  assign last_sample = (MW'(addr_q) == (max_q - MW'(1)));

  // Next-state and datapath updates; abort (start low) outranks a same-cycle tick.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    max_d   = max_q;
    lat_d   = lat_q;
    pref_d  = pref_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    under_d = under_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          max_d   = max_clamp;
          cnt_d   = 32'd0;
          under_d = 1'b0;
          addr_d  = '0;
          state_d = (max_clamp == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (i_wf_tick) under_d = 1'b1;
        if (!i_wf_start) begin
          state_d = IDLE;
        end else begin
          lat_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_wf_tick) under_d = 1'b1;
        if (!i_wf_start) begin
          state_d = IDLE;
        end else if (lat_q == LW'(RAM_LATENCY - 1)) begin
          pref_d  = i_wf_ram_dout;
          state_d = HOLD;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      HOLD: begin
        if (!i_wf_start) begin
          state_d = IDLE;
        end else if (i_wf_tick) begin
          data_d  = pref_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          if (!last_sample) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end else if (i_wf_loop) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!i_wf_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      addr_q  <= '0;
      max_q   <= '0;
      lat_q   <= '0;
      pref_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
      under_q <= 1'b0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= i_wf_start;
      addr_q  <= addr_d;
      max_q   <= max_d;
      lat_q   <= lat_d;
      pref_q  <= pref_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      under_q <= under_d;
      ce_q    <= (state_d == FETCH);
      busy_q  <= (state_d == FETCH) || (state_d == WAIT) || (state_d == HOLD);
      done_q  <= (state_d == DONE);
    end
  end

  assign o_wf_ram_addr   = addr_q;
  assign o_wf_ram_ce     = ce_q;
  assign o_wf_ram_we     = 1'b0;
  assign o_wf_ram_din    = '0;
  assign o_wf_data       = data_q;
  assign o_wf_data_valid = valid_q;
  assign o_wf_read_cnt   = cnt_q;
  assign o_wf_busy       = busy_q;
  assign o_wf_done       = done_q;
  assign o_wf_underrun   = under_q;

endmodule

// File: tb/tb_wf_dpbram_player.sv
// Bench for wf_dpbram_player: latency-modelled DPBRAM, table vectors,
// hand-written corner sequences and randomized playback against a sample model.
module tb_wf_dpbram_player;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_wf_start = 1'b0;
  logic          i_wf_loop = 1'b0;
  logic [31:0]   i_wf_max_cnt = 32'd0;
  logic          i_wf_tick = 1'b0;
  logic [AW-1:0] o_wf_ram_addr;
  logic          o_wf_ram_ce;
  logic          o_wf_ram_we;
  logic [DW-1:0] o_wf_ram_din;
  logic [DW-1:0] i_wf_ram_dout;
  logic [DW-1:0] o_wf_data;
  logic          o_wf_data_valid;
  logic [31:0]   o_wf_read_cnt;
  logic          o_wf_busy;
  logic          o_wf_done;
  logic          o_wf_underrun;

  wf_dpbram_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(RL)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_wf_start(i_wf_start), .i_wf_loop(i_wf_loop),
    .i_wf_max_cnt(i_wf_max_cnt), .i_wf_tick(i_wf_tick),
    .o_wf_ram_addr(o_wf_ram_addr), .o_wf_ram_ce(o_wf_ram_ce), .o_wf_ram_we(o_wf_ram_we),
    .o_wf_ram_din(o_wf_ram_din), .i_wf_ram_dout(i_wf_ram_dout),
    .o_wf_data(o_wf_data), .o_wf_data_valid(o_wf_data_valid),
    .o_wf_read_cnt(o_wf_read_cnt), .o_wf_busy(o_wf_busy), .o_wf_done(o_wf_done),
    .o_wf_underrun(o_wf_underrun)
  );

  always #5 clk = ~clk;

  // DPBRAM port B with RL clocks from ce/addr to valid dout
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    if (o_wf_ram_ce) pipe[0] <= mem[o_wf_ram_addr];
  end
  assign i_wf_ram_dout = pipe[RL-1];

  // Observed activity, sampled mid-cycle
  logic [DW-1:0] got [$];
  int            ce_cnt;
  int            max_addr;
  bit            done_seen;
  always @(negedge clk) begin
    if (o_wf_data_valid) got.push_back(o_wf_data);
    if (o_wf_ram_ce) begin
      ce_cnt++;
      if (int'(o_wf_ram_addr) > max_addr) max_addr = int'(o_wf_ram_addr);
    end
    if (o_wf_done) done_seen = 1'b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    i_wf_tick = 1'b1;
    step();
    i_wf_tick = 1'b0;
  endtask

  task automatic clear_obs();
    got.delete();
    ce_cnt    = 0;
    max_addr  = 0;
    done_seen = 1'b0;
  endtask

  // Plays n ticks with gaps in [gmin,gmax]; optionally slips in an early tick
  // right after an accepted one. Expected results come from the sample rules.
  task automatic play(input string nm, input logic [31:0] mx, input logic lp, input int n,
                      input int gmin, input int gmax, input int early_pct,
                      output int acc, output bit fin);
    int          eff, fetches, exp_max_addr, first_bad, gap, e;
    bit          under;
    logic [DW-1:0] exp_q [$];
    clear_obs();
    eff   = (mx > 32'(DEPTH)) ? int'(DEPTH) : int'(mx);
    acc   = 0;
    under = 1'b0;
    fin   = (eff == 0);
    i_wf_max_cnt = mx;
    i_wf_loop    = lp;
    i_wf_start   = 1'b1;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(gmax, gmin));
      repeat (gap) step();
      tick();
      if (!fin) begin
        exp_q.push_back(mem[acc % eff]);
        acc++;
        if (!lp && acc == eff) fin = 1'b1;
      end
      if (!fin && int'($urandom_range(99, 0)) < early_pct) begin
        e = int'($urandom_range(RL + 1, 1));
        repeat (e - 1) step();
        tick();
        under = 1'b1;
      end
    end
    repeat (8) step();
    fetches      = (eff == 0) ? 0 : (fin ? eff : acc + 1);
    exp_max_addr = (fetches == 0) ? 0 : (((fetches < eff) ? fetches : eff) - 1);
    first_bad = -1;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (first_bad < 0 && got[i] !== exp_q[i]) first_bad = i;
    chk({nm, " read_cnt"}, o_wf_read_cnt, 32'(acc));
    chk({nm, " done"}, {31'd0, o_wf_done}, {31'd0, fin});
    chk({nm, " done_ever"}, {31'd0, done_seen}, {31'd0, fin});
    chk({nm, " underrun"}, {31'd0, o_wf_underrun}, {31'd0, under});
    chk({nm, " valid_pulses"}, 32'(got.size()), 32'(acc));
    chk({nm, " first_bad_sample"}, 32'(first_bad), 32'(-1));
    chk({nm, " ce_count"}, 32'(ce_cnt), 32'(fetches));
    chk({nm, " max_ram_addr"}, 32'(max_addr), 32'(exp_max_addr));
    i_wf_start = 1'b0;
    repeat (2) step();
    chk({nm, " idle_busy"}, {31'd0, o_wf_busy}, 32'd0);
    chk({nm, " idle_done"}, {31'd0, o_wf_done}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] mx;
    logic        lp;
    int          n;
    int          gap;
    int          exp_cnt;
    logic        exp_done;
  } vec_t;

  initial begin
    vec_t vecs [$];
    int   acc;
    bit   fin;
    int   ce_snap;

    vecs.push_back('{32'd4,    1'b0, 4,    10, 4,    1'b1});
    vecs.push_back('{32'd3,    1'b1, 8,    10, 8,    1'b0});
    vecs.push_back('{32'd5000, 1'b0, 1025, 5,  1024, 1'b1});
    vecs.push_back('{32'd0,    1'b0, 3,    6,  0,    1'b1});
    vecs.push_back('{32'd1,    1'b0, 3,    6,  1,    1'b1});
    vecs.push_back('{32'd1,    1'b1, 3,    6,  3,    1'b0});
    vecs.push_back('{32'd7,    1'b0, 5,    6,  5,    1'b0});

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i * 3);
    for (int i = 0; i < int'(RL); i++) pipe[i] = '0;

    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst data", 32'(o_wf_data), 32'd0);
    chk("rst valid", {31'd0, o_wf_data_valid}, 32'd0);
    chk("rst read_cnt", o_wf_read_cnt, 32'd0);
    chk("rst ce_addr", {21'd0, o_wf_ram_ce, o_wf_ram_addr}, 32'd0);
    chk("rst status", {29'd0, o_wf_busy, o_wf_done, o_wf_underrun}, 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[v]) begin
      play($sformatf("vec%0d", v), vecs[v].mx, vecs[v].lp, vecs[v].n,
           vecs[v].gap, vecs[v].gap, 0, acc, fin);
      chk($sformatf("vec%0d table_cnt", v), 32'(acc), 32'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d table_done", v), {31'd0, fin}, {31'd0, vecs[v].exp_done});
    end

    // Underrun, then abort in WAIT after two samples, then restart
    clear_obs();
    i_wf_max_cnt = 32'd4;
    i_wf_loop    = 1'b0;
    i_wf_start   = 1'b1;
    repeat (10) step();
    tick();
    tick();
    chk("ur underrun", {31'd0, o_wf_underrun}, 32'd1);
    chk("ur cnt_held", o_wf_read_cnt, 32'd1);
    repeat (10) step();
    tick();
    step();
    chk("ur next_sample", 32'(o_wf_data), 32'd3);
    chk("ur cnt", o_wf_read_cnt, 32'd2);
    i_wf_start = 1'b0;
    step();
    chk("abort busy", {31'd0, o_wf_busy}, 32'd0);
    chk("abort data_held", 32'(o_wf_data), 32'd3);
    chk("abort cnt_held", o_wf_read_cnt, 32'd2);
    ce_snap = ce_cnt;
    repeat (5) step();
    chk("abort no_ce", 32'(ce_cnt), 32'(ce_snap));
    i_wf_start = 1'b1;
    step();
    chk("restart cnt", o_wf_read_cnt, 32'd0);
    chk("restart underrun", {31'd0, o_wf_underrun}, 32'd0);
    got.delete();
    repeat (10) step();
    tick();
    step();
    chk("restart pulses", 32'(got.size()), 32'd1);
    chk("restart first", 32'(o_wf_data), 32'd0);

    // Asynchronous reset while parked in HOLD with a non-zero setpoint
    repeat (10) step();
    tick();
    repeat (10) step();
    chk("pre_rst data", 32'(o_wf_data), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async data", 32'(o_wf_data), 32'd0);
    chk("async read_cnt", o_wf_read_cnt, 32'd0);
    chk("async status", {28'd0, o_wf_busy, o_wf_done, o_wf_underrun, o_wf_ram_ce}, 32'd0);
    i_wf_start = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // max = 0 goes straight to DONE without touching the RAM
    clear_obs();
    i_wf_max_cnt = 32'd0;
    i_wf_start   = 1'b1;
    repeat (2) step();
    chk("max0 done", {31'd0, o_wf_done}, 32'd1);
    chk("max0 ce", 32'(ce_cnt), 32'd0);
    i_wf_start = 1'b0;
    repeat (2) step();

    // Randomized playback with random RAM content
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'($urandom);
    for (int r = 0; r < 20; r++) begin
      play($sformatf("rnd%0d", r), 32'($urandom_range(12, 0)), 1'($urandom_range(1, 0)),
           int'($urandom_range(25, 1)), 5, 8, 25, acc, fin);
    end

    chk("tied we", {31'd0, o_wf_ram_we}, 32'd0);
    chk("tied din", 32'(o_wf_ram_din), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
